// File: rtl/hazard_pkg.sv
// hazard_pkg: stage indices, long-op FSM states, scoreboard entry layout and forward encodings
// shared by the hazard unit.
package hazard_pkg;
    localparam int ST_F = 0;
    localparam int ST_D = 1;
    localparam int ST_E = 2;
    localparam int ST_M = 3;
    localparam int SB_CNT_W = 8;
    localparam int SB_AGE_W = 4;
    localparam int FWD_RF = 0;
    localparam int FWD_E = 1;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} lfsm_e;
    typedef struct packed {
        logic                busy;
        logic                is_long;
        logic [SB_CNT_W-1:0] cnt;
        logic [SB_AGE_W-1:0] age;
    } sb_entry_t;
    function automatic logic [31:0] upto(input int s);
        return (32'd1 << (s + 1)) - 32'd1;
    endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one register's scoreboard slot with latency countdown, age tracking,
// exception clear and forward-select generation.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int EX_DEPTH = 3,
    parameter int EXC_STAGE = 3,
    parameter int LAT_W = 3,
    parameter int FW = 2,
    localparam int NST = EX_DEPTH + 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue,
    input  logic             is_long,
    input  logic [LAT_W-1:0] lat,
    input  logic             advance,
    input  logic             lu_ack,
    input  logic             exc_clr,
    input  logic [NST-1:0]   flush,
    output logic [FW-1:0]    fwd,
    output logic             pend,
    output logic             young
);
    sb_entry_t ent, nxt;
    logic      into_flush;
    always_comb begin
        into_flush = 1'b0;
        // an entry at age i moves into stage ST_M+i; a flushed target stage kills it
        for (int i = 0; i < EX_DEPTH - 1; i++)
            into_flush = into_flush | (ent.age == SB_AGE_W'(i) && flush[ST_M + i]);
        nxt = ent;
        if (ent.is_long && lu_ack) begin
            nxt.cnt = '0;
            nxt.is_long = 1'b0;
        end
        if (advance && ent.busy) begin
            nxt.cnt = (nxt.cnt == '0 || nxt.is_long) ? nxt.cnt : nxt.cnt - SB_CNT_W'(1);
            nxt.age = ent.age + SB_AGE_W'(1);
            if (ent.age == SB_AGE_W'(EX_DEPTH - 1) || into_flush) nxt = '0;
        end
        if (exc_clr && ent.age <= SB_AGE_W'(EXC_STAGE - 2)) nxt = '0;
        if (issue) nxt = '{busy: 1'b1, is_long: is_long, cnt: is_long ? '1 : SB_CNT_W'(lat), age: '0};
    end
    assign fwd = (ent.busy && ent.cnt == '0) ? FW'(ent.age) + FW'(FWD_E) : FW'(FWD_RF);
    assign pend = ent.busy && ent.cnt != '0;
    assign young = ent.busy && ent.age == '0;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) ent <= '0;
        else ent <= nxt;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register RAW scoreboard, D-stage forward selects, long-op FSM and
// prioritised stall/flush arbiter. Define HZ_PERF_CNT_EN to add stall/flush perf counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int EX_DEPTH = 3,
    parameter int LAT_W = 3,
    parameter int EXC_STAGE = 3,
    localparam int NST = EX_DEPTH + 2,
    localparam int RW = $clog2(NREG),
    localparam int FW = $clog2(EX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             d_valid,
    input  logic [RW-1:0]    d_rs,
    input  logic [RW-1:0]    d_rt,
    input  logic             d_rs_used,
    input  logic             d_rt_used,
    input  logic             d_early,
    input  logic             d_wen,
    input  logic [RW-1:0]    d_waddr,
    input  logic [LAT_W-1:0] d_lat,
    input  logic             d_long,
    input  logic             lu_done,
    input  logic             exc_valid,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic [NST-1:0]   stall_ext,
    input  logic [NST-1:0]   flush_ext,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [NST-1:0]   stall,
    output logic [NST-1:0]   flush
`ifdef HZ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_raw_stall,
    output logic [31:0]      perf_mem_stall,
    output logic [31:0]      perf_flush
`endif
);
    localparam logic [NST-1:0] M_FD = NST'(upto(ST_D));
    localparam logic [NST-1:0] M_FDE = NST'(upto(ST_E));
    localparam logic [NST-1:0] M_EXC = NST'(upto(EXC_STAGE));
    localparam logic [NST-1:0] B_E = NST'(1) << ST_E;
    localparam logic [NST-1:0] B_M = NST'(1) << ST_M;
    lfsm_e           state;
    logic [FW-1:0]   fwd_v [NREG];
    logic [NREG-1:0] pend_v, young_v;
    logic            raw_a, raw_b, raw_stall, r1, r2, r3, r4, r5, go, issue, lu_ack;
    assign fwd_v[0] = '0;
    assign pend_v[0] = 1'b0;
    assign young_v[0] = 1'b0;
    for (genvar g = 1; g < NREG; g++) begin : g_ent
        hazard_sb_entry #(
            .EX_DEPTH (EX_DEPTH),
            .EXC_STAGE(EXC_STAGE),
            .LAT_W    (LAT_W),
            .FW       (FW)
        ) u_ent (
            .clk    (clk),
            .resetn (resetn),
            .issue  (issue && d_waddr == RW'(g)),
            .is_long(d_long),
            .lat    (d_lat),
            .advance(!stall[ST_E]),
            .lu_ack (lu_ack),
            .exc_clr(r3),
            .flush  (flush),
            .fwd    (fwd_v[g]),
            .pend   (pend_v[g]),
            .young  (young_v[g])
        );
    end
    always_comb begin
        raw_a = d_rs_used && (pend_v[d_rs] || (d_early && young_v[d_rs]));
        raw_b = d_rt_used && (pend_v[d_rt] || (d_early && young_v[d_rt]));
        raw_stall = d_valid && (raw_a || raw_b);
        r1 = dmem_busy;
        r2 = !r1 && exc_valid && imem_busy;
        r3 = !r1 && exc_valid && !imem_busy;
        r4 = !r1 && !exc_valid && state == WAIT && !lu_done;
        r5 = !r1 && !exc_valid && !r4 && (imem_busy || raw_stall);
        stall = ((r1 || r2) ? '1 : r4 ? M_FDE : r5 ? M_FD : '0) | stall_ext;
        flush = (r3 ? M_EXC : r4 ? B_M : r5 ? B_E : '0) | flush_ext;
        go = d_valid && !stall[ST_D] && !flush[ST_D] && !flush[ST_E];
        issue = go && d_wen && d_waddr != '0;
        lu_ack = state == WAIT && lu_done && !dmem_busy;
    end
    assign fwd_a = fwd_v[d_rs];
    assign fwd_b = fwd_v[d_rt];
    // a busy data memory freezes the whole hazard state, including a pending lu_done
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else if (!dmem_busy)
            state <= (state == WAIT) ? ((lu_done || r3) ? IDLE : WAIT) : ((go && d_long) ? WAIT : IDLE);
`ifdef HZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            perf_raw_stall <= '0;
            perf_mem_stall <= '0;
            perf_flush <= '0;
        end else begin
            perf_raw_stall <= perf_raw_stall + 32'(r5 && raw_stall);
            perf_mem_stall <= perf_mem_stall + 32'(r1);
            perf_flush <= perf_flush + 32'(r3);
        end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven self-check of hazard_scoreboard; expected outputs are queued
// when a vector is driven and compared when the outputs are sampled.
module tb_hazard_scoreboard;
    logic       clk = 1'b0, resetn = 1'b0;
    logic       d_valid, d_rs_used, d_rt_used, d_early, d_wen, d_long;
    logic       lu_done, exc_valid, imem_busy, dmem_busy;
    logic [4:0] d_rs, d_rt, d_waddr, stall_ext, flush_ext, stall, flush;
    logic [2:0] d_lat;
    logic [1:0] fwd_a, fwd_b;
    int         checks = 0, errors = 0;
    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       early, wen;
        logic [4:0] wa;
        logic [2:0] lat;
        logic       lng, lu, exc, imem, dmem;
        logic [4:0] sx, fx, st, fl;
        logic [1:0] fa, fb;
    } vec_t;
    typedef struct {
        logic [4:0] st, fl;
        logic [1:0] fa, fb;
        int         idx;
    } exp_t;
    exp_t expq[$];
    vec_t tbl[35];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk      (clk),
        .resetn   (resetn),
        .d_valid  (d_valid),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_rs_used(d_rs_used),
        .d_rt_used(d_rt_used),
        .d_early  (d_early),
        .d_wen    (d_wen),
        .d_waddr  (d_waddr),
        .d_lat    (d_lat),
        .d_long   (d_long),
        .lu_done  (lu_done),
        .exc_valid(exc_valid),
        .imem_busy(imem_busy),
        .dmem_busy(dmem_busy),
        .stall_ext(stall_ext),
        .flush_ext(flush_ext),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b),
        .stall    (stall),
        .flush    (flush)
    );

    // ctl = {lu_done, exc_valid, imem_busy, dmem_busy}
    function automatic vec_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                input logic early, input logic wen, input logic [4:0] wa,
                                input logic [2:0] lat, input logic lng, input logic [3:0] ctl,
                                input logic [4:0] st, input logic [4:0] fl,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.valid = valid; v.rs = rs; v.rt = rt; v.early = early; v.wen = wen; v.wa = wa;
        v.lat = lat; v.lng = lng;
        {v.lu, v.exc, v.imem, v.dmem} = ctl;
        v.sx = '0; v.fx = '0; v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %b, expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        d_valid = v.valid; d_rs = v.rs; d_rt = v.rt; d_rs_used = 1'b1; d_rt_used = 1'b1;
        d_early = v.early; d_wen = v.wen; d_waddr = v.wa; d_lat = v.lat; d_long = v.lng;
        lu_done = v.lu; exc_valid = v.exc; imem_busy = v.imem; dmem_busy = v.dmem;
        stall_ext = v.sx; flush_ext = v.fx;
    endtask

    task automatic apply(input int i);
        exp_t e;
        @(posedge clk);
        #1;
        drive(tbl[i]);
        expq.push_back('{st: tbl[i].st, fl: tbl[i].fl, fa: tbl[i].fa, fb: tbl[i].fb, idx: i});
        @(negedge clk);
        e = expq.pop_front();
        chk("stall", e.idx, stall, e.st);
        chk("flush", e.idx, flush, e.fl);
        chk("fwd_a", e.idx, 5'(fwd_a), 5'(e.fa));
        chk("fwd_b", e.idx, 5'(fwd_b), 5'(e.fb));
    endtask

    initial begin
        //            vl rs  rt  er wn wa  lt lg ctl      stall     flush     fa fb
        tbl[0]  = mk(1, 1,  2,  0, 1, 3,  0, 0, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[1]  = mk(1, 3,  0,  0, 1, 4,  0, 0, 4'b0000, 5'b00000, 5'b00000, 1, 0);
        tbl[2]  = mk(1, 4,  3,  0, 1, 5,  1, 0, 4'b0000, 5'b00000, 5'b00000, 1, 2);
        tbl[3]  = mk(1, 5,  3,  0, 1, 6,  0, 0, 4'b0000, 5'b00011, 5'b00100, 0, 3);
        tbl[4]  = mk(1, 5,  3,  0, 1, 6,  0, 0, 4'b0000, 5'b00000, 5'b00000, 2, 0);
        tbl[5]  = mk(1, 6,  5,  0, 1, 7,  0, 0, 4'b0000, 5'b00000, 5'b00000, 1, 3);
        tbl[6]  = mk(1, 7,  0,  1, 0, 0,  0, 0, 4'b0000, 5'b00011, 5'b00100, 1, 0);
        tbl[7]  = mk(1, 7,  0,  1, 0, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 2, 0);
        tbl[8]  = mk(1, 7,  0,  0, 1, 8,  0, 1, 4'b0000, 5'b00000, 5'b00000, 3, 0);
        tbl[9]  = mk(1, 8,  0,  0, 0, 0,  0, 0, 4'b0000, 5'b00111, 5'b01000, 0, 0);
        tbl[10] = mk(1, 8,  0,  0, 0, 0,  0, 0, 4'b0000, 5'b00111, 5'b01000, 0, 0);
        tbl[11] = mk(1, 1,  0,  0, 0, 0,  0, 0, 4'b1000, 5'b00000, 5'b00000, 0, 0);
        tbl[12] = mk(1, 8,  0,  0, 1, 9,  1, 0, 4'b0000, 5'b00000, 5'b00000, 2, 0);
        tbl[13] = mk(1, 9,  8,  0, 1, 10, 0, 0, 4'b0100, 5'b00000, 5'b01111, 0, 3);
        tbl[14] = mk(1, 9,  8,  0, 1, 10, 0, 0, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[15] = mk(1, 10, 0,  1, 0, 0,  0, 0, 4'b0101, 5'b11111, 5'b00000, 1, 0);
        tbl[16] = mk(1, 10, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 1, 0);
        tbl[17] = mk(1, 10, 0,  0, 0, 0,  0, 0, 4'b0110, 5'b11111, 5'b00000, 2, 0);
        tbl[18] = mk(0, 10, 0,  0, 0, 0,  0, 0, 4'b0010, 5'b00011, 5'b00100, 2, 0);
        tbl[19] = mk(1, 10, 0,  0, 1, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 3, 0);
        tbl[20] = mk(1, 0,  10, 0, 0, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[21] = mk(1, 0,  0,  0, 1, 11, 0, 1, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[22] = mk(0, 11, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00111, 5'b01000, 0, 0);
        tbl[23] = mk(0, 11, 0,  0, 0, 0,  0, 0, 4'b0100, 5'b00000, 5'b01111, 0, 0);
        tbl[24] = mk(1, 11, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[25] = mk(0, 0,  0,  0, 0, 0,  0, 0, 4'b1000, 5'b00000, 5'b00000, 0, 0);
        tbl[26] = mk(0, 0,  0,  0, 0, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[27] = mk(1, 0,  0,  0, 1, 12, 0, 1, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[28] = mk(0, 12, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00111, 5'b01000, 0, 0);
        tbl[29] = mk(1, 12, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[30] = mk(0, 0,  0,  0, 0, 0,  0, 0, 4'b0000, 5'b10000, 5'b00001, 0, 0);
        tbl[30].sx = 5'b10000;
        tbl[30].fx = 5'b00001;
        tbl[31] = mk(1, 0,  0,  0, 1, 13, 2, 0, 4'b0000, 5'b00000, 5'b00000, 0, 0);
        tbl[32] = mk(1, 13, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00011, 5'b00100, 0, 0);
        tbl[33] = mk(1, 13, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00011, 5'b00100, 0, 0);
        tbl[34] = mk(1, 13, 0,  0, 0, 0,  0, 0, 4'b0000, 5'b00000, 5'b00000, 3, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b0, 5'b0, 0, 0));
        @(negedge clk);
        chk("reset_stall", -1, stall, 5'b0);
        chk("reset_flush", -1, flush, 5'b0);
        chk("reset_fwd_a", -1, 5'(fwd_a), 5'b0);
        chk("reset_fwd_b", -1, 5'(fwd_b), 5'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i <= 28; i++) apply(i);
        // asynchronous reset while the long-op FSM is waiting
        #2 resetn = 1'b0;
        #1;
        chk("wait_reset_stall", 28, stall, 5'b0);
        chk("wait_reset_flush", 28, flush, 5'b0);
        chk("wait_reset_fwd_a", 28, 5'(fwd_a), 5'b0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 29; i < 35; i++) apply(i);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
